// File: rtl/veer_lsu_wb_pkg.sv
// Shared types and helpers for the VeeR LSU to Wishbone data-memory bridge.
package veer_lsu_wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } bridge_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } lsu_req_t;

    localparam logic [3:0] SEL_FULL = 4'hF;

    function automatic logic [3:0] req_sel(lsu_req_t req);
        return req.we ? req.be : SEL_FULL;
    endfunction

    // A store with no enabled bytes has nothing to put on the bus.
    function automatic logic req_skip(lsu_req_t req);
        return req.we && (req.be == 4'b0000);
    endfunction

endpackage

// File: rtl/veer_lsu_wb_watchdog.sv
// Saturating bus-cycle watchdog; expired_o flags the last permitted BUS cycle.
module veer_lsu_wb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != CntLast)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = en_i && (cnt_q == CntLast);

endmodule

// File: rtl/veer_lsu_wb_bridge.sv
// VeeR LSU request port to Wishbone classic data-memory adapter with a one-entry
// pending buffer, in-order single-cycle responses and a bus watchdog.
module veer_lsu_wb_bridge
    import veer_lsu_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req_i,
    output logic        lsu_gnt_o,
    input  logic        lsu_we_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [3:0]  lsu_be_i,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        data_mem_cyc_o,
    output logic        data_mem_stb_o,
    output logic        data_mem_we_o,
    output logic [31:0] data_mem_addr_o,
    output logic [31:0] data_mem_data_o,
    output logic [3:0]  data_mem_sel_o,
    input  logic [31:0] data_mem_data_i,
    input  logic        data_mem_ack_i,
    input  logic        data_mem_err_i
);

    bridge_state_e state_q;
    lsu_req_t      req_in, pend_q, pick, load_src;
    logic          pend_valid_q, stage_q;
    logic          accept, use_stage, use_pend, launch, pick_skip;
    logic          pend_load, bus_done, load_cur, expired;

    assign lsu_gnt_o = !rst && !pend_valid_q;

    veer_lsu_wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q != BUS),
        .en_i     (state_q == BUS),
        .expired_o(expired)
    );

    // stage_q: the bus registers already hold the pending request, moved there
    // on BUS exit so the pending slot (and gnt) frees up during RESP.
    always_comb begin
        req_in    = '{we: lsu_we_i, addr: lsu_addr_i, wdata: lsu_wdata_i, be: lsu_be_i};
        accept    = lsu_req_i && lsu_gnt_o;
        use_stage = (state_q == RESP) && stage_q;
        use_pend  = (state_q == RESP) && !stage_q && pend_valid_q;
        pick      = use_pend ? pend_q : req_in;
        launch    = (state_q != BUS) && (use_stage || use_pend || accept);
        pick_skip = use_stage ? (data_mem_we_o && (data_mem_sel_o == 4'b0000))
                              : req_skip(pick);
        pend_load = accept && ((state_q == BUS) || use_stage);
        bus_done  = (state_q == BUS) && (data_mem_ack_i || data_mem_err_i || expired);
        load_src  = (state_q == BUS) ? pend_q : pick;
        load_cur  = bus_done ? pend_valid_q : (launch && !use_stage);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            pend_q          <= '0;
            pend_valid_q    <= 1'b0;
            stage_q         <= 1'b0;
            data_mem_cyc_o  <= 1'b0;
            data_mem_stb_o  <= 1'b0;
            data_mem_we_o   <= 1'b0;
            data_mem_addr_o <= '0;
            data_mem_data_o <= '0;
            data_mem_sel_o  <= '0;
            lsu_rvalid_o    <= 1'b0;
            lsu_rdata_o     <= '0;
            lsu_err_o       <= 1'b0;
        end else begin
            lsu_rvalid_o <= 1'b0;
            lsu_rdata_o  <= '0;
            lsu_err_o    <= 1'b0;

            if (pend_load) begin
                pend_q       <= req_in;
                pend_valid_q <= 1'b1;
            end

            if (load_cur) begin
                data_mem_we_o   <= load_src.we;
                data_mem_addr_o <= load_src.addr & 32'hFFFF_FFFC;
                data_mem_data_o <= load_src.wdata;
                data_mem_sel_o  <= req_sel(load_src);
            end

            unique case (state_q)
                BUS: begin
                    if (bus_done) begin
                        data_mem_cyc_o <= 1'b0;
                        data_mem_stb_o <= 1'b0;
                        lsu_rvalid_o   <= 1'b1;
                        state_q        <= RESP;
                        stage_q        <= pend_valid_q;
                        if (pend_valid_q) begin
                            pend_valid_q <= 1'b0;
                        end
                        // Error beats ack; a bare expiry is also an error.
                        if (data_mem_err_i || !data_mem_ack_i) begin
                            lsu_err_o <= 1'b1;
                        end else if (!data_mem_we_o) begin
                            lsu_rdata_o <= data_mem_data_i;
                        end
                    end
                end
                default: begin
                    stage_q <= 1'b0;
                    if (use_pend) begin
                        pend_valid_q <= 1'b0;
                    end
                    if (!launch) begin
                        state_q <= IDLE;
                    end else if (pick_skip) begin
                        state_q      <= RESP;
                        lsu_rvalid_o <= 1'b1;
                    end else begin
                        state_q        <= BUS;
                        data_mem_cyc_o <= 1'b1;
                        data_mem_stb_o <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_veer_lsu_wb_bridge.sv
// Directed bench for veer_lsu_wb_bridge: vector table plus back-to-back and reset sequences.
module tb_veer_lsu_wb_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_req_i = 1'b0, lsu_we_i = 1'b0;
    logic [31:0] lsu_addr_i = '0, lsu_wdata_i = '0;
    logic [3:0]  lsu_be_i = '0;
    logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        data_mem_cyc_o, data_mem_stb_o, data_mem_we_o;
    logic [31:0] data_mem_addr_o, data_mem_data_o, data_mem_data_i;
    logic [3:0]  data_mem_sel_o;
    logic        data_mem_ack_i = 1'b0, data_mem_err_i = 1'b0;

    logic        auto_mem = 1'b0;
    logic [31:0] mem_rdata = '0;
    localparam logic [31:0] MemKey = 32'hA500_0000;

    assign data_mem_data_i = auto_mem ? (data_mem_addr_o ^ MemKey) : mem_rdata;

    always #5 clk = ~clk;

    veer_lsu_wb_bridge #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_req_i      (lsu_req_i),
        .lsu_gnt_o      (lsu_gnt_o),
        .lsu_we_i       (lsu_we_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_be_i       (lsu_be_i),
        .lsu_rvalid_o   (lsu_rvalid_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .lsu_err_o      (lsu_err_o),
        .data_mem_cyc_o (data_mem_cyc_o),
        .data_mem_stb_o (data_mem_stb_o),
        .data_mem_we_o  (data_mem_we_o),
        .data_mem_addr_o(data_mem_addr_o),
        .data_mem_data_o(data_mem_data_o),
        .data_mem_sel_o (data_mem_sel_o),
        .data_mem_data_i(data_mem_data_i),
        .data_mem_ack_i (data_mem_ack_i),
        .data_mem_err_i (data_mem_err_i)
    );

    // term: 0 ack, 1 err, 2 ack+err, 3 never terminate
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ws;
        int          term;
        logic [31:0] mem;
        logic [31:0] e_addr;
        logic [3:0]  e_sel;
        int          e_cyc;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    localparam int NVec = 8;
    vec_t vecs [NVec];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Back-to-back helper state: memory acks on the 2nd cycle of every bus cycle.
    int          bus_cnt, rises, overlap;
    logic        prev_cyc;
    logic [31:0] rsp_q[$];

    task automatic tick();
        if (data_mem_cyc_o) begin
            if (!prev_cyc) rises++;
            bus_cnt++;
            data_mem_ack_i = (bus_cnt == 2);
        end else begin
            bus_cnt = 0;
            data_mem_ack_i = 1'b0;
        end
        prev_cyc = data_mem_cyc_o;
        if (lsu_rvalid_o) begin
            rsp_q.push_back(lsu_rdata_o);
            if (data_mem_cyc_o) overlap++;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("Result: errors=%0d of %0d checks (global time limit hit)", errors + 1, checks + 1);
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t v;
        int   cyc_cnt, bad, lat, got, rv_cnt, cy_cnt;
        logic fire;
        logic [31:0] r_rdata;
        logic        r_err;

        vecs[0] = '{1'b0, 32'h0000_0104, 32'h0, 4'h0, 2, 0, 32'hCAFE_F00D,
                    32'h0000_0104, 4'hF, 3, 32'hCAFE_F00D, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0203, 32'h1122_3344, 4'b1000, 0, 0, 32'hDEAD_BEEF,
                    32'h0000_0200, 4'b1000, 1, 32'h0, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0FFF, 32'h0, 4'h0, 1, 1, 32'h1234_5678,
                    32'h0000_0FFC, 4'hF, 2, 32'h0, 1'b1};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 2, 32'h5555_AAAA,
                    32'h0000_0010, 4'hF, 1, 32'h0, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 3, 32'hFFFF_FFFF,
                    32'h0000_0020, 4'hF, 8, 32'h0, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0030, 32'h0000_0099, 4'b0000, 0, 0, 32'h7777_7777,
                    32'h0, 4'h0, 0, 32'h0, 1'b0};
        vecs[6] = '{1'b1, 32'hFFFF_FFFE, 32'hA5A5_5A5A, 4'b0011, 3, 0, 32'h0BAD_0BAD,
                    32'hFFFF_FFFC, 4'b0011, 4, 32'h0, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_0500, 32'h0, 4'h0, 7, 0, 32'h0BAD_CAFE,
                    32'h0000_0500, 4'hF, 8, 32'h0BAD_CAFE, 1'b0};

        // Reset state
        @(negedge clk);
        check("rst_cyc", data_mem_cyc_o, 0);
        check("rst_stb", data_mem_stb_o, 0);
        check("rst_gnt", lsu_gnt_o, 0);
        check("rst_rvalid", lsu_rvalid_o, 0);
        rst = 1'b0;
        #1;
        check("gnt_after_release", lsu_gnt_o, 1);
        @(negedge clk);

        // Terminations outside BUS are ignored
        data_mem_ack_i = 1'b1;
        data_mem_err_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_ack_rvalid", lsu_rvalid_o, 0);
        check("idle_ack_cyc", data_mem_cyc_o, 0);
        data_mem_ack_i = 1'b0;
        data_mem_err_i = 1'b0;

        // Single transactions from the table
        for (int i = 0; i < NVec; i++) begin
            v = vecs[i];
            mem_rdata = v.mem;
            check($sformatf("v%0d_gnt", i), lsu_gnt_o, 1);
            lsu_req_i   = 1'b1;
            lsu_we_i    = v.we;
            lsu_addr_i  = v.addr;
            lsu_wdata_i = v.wdata;
            lsu_be_i    = v.be;
            @(negedge clk);
            lsu_req_i = 1'b0;
            cyc_cnt = 0; bad = 0; lat = -1; got = 0; r_rdata = '0; r_err = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (lsu_rvalid_o) begin
                    got = 1; lat = c; r_rdata = lsu_rdata_o; r_err = lsu_err_o;
                    break;
                end
                if (data_mem_cyc_o) begin
                    cyc_cnt++;
                    if (!data_mem_stb_o || data_mem_addr_o !== v.e_addr ||
                        data_mem_sel_o !== v.e_sel || data_mem_we_o !== v.we ||
                        (v.we && data_mem_data_o !== v.wdata)) bad++;
                    fire = (v.term != 3) && (cyc_cnt == v.ws + 1);
                    data_mem_ack_i = fire && (v.term != 1);
                    data_mem_err_i = fire && (v.term != 0);
                end else begin
                    data_mem_ack_i = 1'b0;
                    data_mem_err_i = 1'b0;
                end
                @(negedge clk);
            end
            data_mem_ack_i = 1'b0;
            data_mem_err_i = 1'b0;
            check($sformatf("v%0d_rvalid_seen", i), got, 1);
            check($sformatf("v%0d_cyc_cycles", i), cyc_cnt, v.e_cyc);
            check($sformatf("v%0d_latency", i), lat, v.e_cyc);
            check($sformatf("v%0d_bus_field_errs", i), bad, 0);
            check($sformatf("v%0d_rdata", i), r_rdata, v.e_rdata);
            check($sformatf("v%0d_err", i), r_err, v.e_err);
            @(negedge clk);
            check($sformatf("v%0d_rvalid_single", i), lsu_rvalid_o, 0);
        end

        // Back-to-back: three loads, memory acks after one wait state
        auto_mem = 1'b1;
        bus_cnt = 0; rises = 0; overlap = 0; prev_cyc = 1'b0;
        rsp_q.delete();
        lsu_we_i = 1'b0;
        lsu_be_i = 4'h0;
        lsu_req_i = 1'b1;
        lsu_addr_i = 32'h0000_0040;
        tick();
        check("b2b_gnt_second", lsu_gnt_o, 1);
        lsu_addr_i = 32'h0000_0044;
        tick();
        check("b2b_gnt_drop", lsu_gnt_o, 0);
        lsu_addr_i = 32'h0000_0048;
        tick();
        check("b2b_gnt_first_resp", lsu_gnt_o, 1);
        check("b2b_rvalid_first_resp", lsu_rvalid_o, 1);
        tick();
        lsu_req_i = 1'b0;
        for (int c = 0; c < 30 && rsp_q.size() < 3; c++) tick();
        data_mem_ack_i = 1'b0;
        check("b2b_rsp_count", rsp_q.size(), 3);
        check("b2b_rsp0", (rsp_q.size() > 0) ? rsp_q[0] : 32'hX, 32'hA500_0040);
        check("b2b_rsp1", (rsp_q.size() > 1) ? rsp_q[1] : 32'hX, 32'hA500_0044);
        check("b2b_rsp2", (rsp_q.size() > 2) ? rsp_q[2] : 32'hX, 32'hA500_0048);
        check("b2b_bus_cycles", rises, 3);
        check("b2b_cyc_rvalid_overlap", overlap, 0);
        auto_mem = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset while in BUS with a pending request
        lsu_req_i = 1'b1;
        lsu_we_i = 1'b0;
        lsu_addr_i = 32'h0000_0080;
        @(negedge clk);
        check("rstmid_cyc_up", data_mem_cyc_o, 1);
        lsu_we_i = 1'b1;
        lsu_addr_i = 32'h0000_0084;
        lsu_be_i = 4'hF;
        @(negedge clk);
        lsu_req_i = 1'b0;
        check("rstmid_pend_full", lsu_gnt_o, 0);
        #2 rst = 1'b1;
        #1;
        check("rstmid_cyc_async", data_mem_cyc_o, 0);
        check("rstmid_stb_async", data_mem_stb_o, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_gnt_release", lsu_gnt_o, 1);
        rv_cnt = 0; cy_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (lsu_rvalid_o) rv_cnt++;
            if (data_mem_cyc_o) cy_cnt++;
        end
        check("rstmid_no_rvalid", rv_cnt, 0);
        check("rstmid_no_cyc", cy_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/veer_lsu_wb_bridge.md
# veer_lsu_wb_bridge

Adapter between the VeeR core's load/store request port and the Controller's Wishbone classic data-memory port (data_mem_*). It registers each LSU request, holds it stable for a full Wishbone cycle, and generates byte selects and word-aligned addresses. It also buffers one follow-on request and returns a single-cycle response carrying read data and error status. A watchdog terminates bus cycles the memory never acknowledges.

## Interface
- TIMEOUT_CYCLES, 1024: maximum BUS-state cycles before forced termination; must be ≥ 2.
- clk  in  1  core clock (clk_core domain).
- rst  in  1  reset; asynchronous, active-high.
- lsu_req_i  in  1  request valid.
- lsu_gnt_o  out  1  request accepted when lsu_req_i && lsu_gnt_o.
- lsu_we_i  in  1  1 = store.
- lsu_addr_i  in  32  byte address.
- lsu_wdata_i  in  32  store data.
- lsu_be_i  in  4  store byte enables.
- lsu_rvalid_o  out  1  one-cycle response pulse.
- lsu_rdata_o  out  32  load data; valid with lsu_rvalid_o.
- lsu_err_o  out  1  bus error or timeout; valid with lsu_rvalid_o.
- data_mem_cyc_o, data_mem_stb_o, data_mem_we_o  out  1  Wishbone cycle, strobe, write.
- data_mem_addr_o  out  32  word-aligned address.
- data_mem_data_o  out  32  write data.
- data_mem_sel_o  out  4  byte selects.
- data_mem_data_i  in  32  read data.
- data_mem_ack_i, data_mem_err_i  in  1  termination.

## Operation
- States: IDLE, BUS, RESP.
- lsu_gnt_o = !pend_valid.
  - In IDLE or RESP, an accepted request loads the bus registers.
  - In BUS, an accepted request loads the one-entry pending buffer.
- IDLE: on accept, go to BUS. A store with be = 4'b0000 skips the bus and goes to RESP with err = 0.
- BUS:
  - cyc = stb = 1.
  - we from the request.
  - addr = {addr[31:2], 2'b00}.
  - sel = be for stores, 4'hF for loads.
  - data_o = wdata.
- BUS exit, all go to RESP:
  - ack_i: capture data_i for loads.
  - err_i: err = 1.
  - Watchdog reaches TIMEOUT_CYCLES−1 without termination: err = 1.
  - ack_i and err_i together: err wins, rdata = 0.
- RESP:
  - cyc = stb = 0.
  - lsu_rvalid_o = 1; lsu_rdata_o = captured data, or 0 for stores and errors.
  - Next state: if pend_valid, move pending into the bus registers and go to BUS; else if a request is accepted this cycle, go to BUS; else IDLE.
- ack_i and err_i outside BUS are ignored.
- Requests are answered strictly in order.

## Timing
- Reset values: all outputs 0, state IDLE, pend_valid 0. lsu_gnt_o goes to 1 as soon as rst releases.
- Reset mid-transaction: cyc/stb drop asynchronously, the pending entry is discarded, and no response is issued.
- Accept at cycle N → cyc/stb high at N+1. Ack at cycle M → lsu_rvalid_o at M+1 and cyc low at M+1.
- Minimum one idle bus cycle between Wishbone cycles. Throughput is one transaction per (2 + wait states) cycles.
- Bus outputs are registered and stable for the whole BUS state.
- Watchdog:
  - Counter clears on BUS entry and saturates; width $clog2(TIMEOUT_CYCLES).
  - A never-acked cycle occupies exactly TIMEOUT_CYCLES BUS cycles.
- Pending full (lsu_gnt_o = 0) while lsu_req_i = 1: the core must hold its request; the bridge samples nothing.

## Structure
- Package veer_lsu_wb_pkg:
  - bridge_state_e {IDLE, BUS, RESP}.
  - lsu_req_t struct {we, addr[31:0], wdata[31:0], be[3:0]}.
  - SEL_FULL = 4'hF.
- Sub-module veer_lsu_wb_watchdog: counter with clear and enable inputs and an expired output, parameterised by TIMEOUT_CYCLES.
- Pending buffer and FSM live in the top module.

## Test plan
- Load 0x0000_0104, memory acks after 2 wait states with 0xCAFE_F00D:
  - cyc high 3 cycles, addr 0x0000_0104, sel 4'hF.
  - lsu_rvalid_o 1 cycle later with rdata 0xCAFE_F00D, err 0.
- Store 0x0000_0203, data 0x1122_3344, be 4'b1000:
  - addr 0x0000_0200, sel 4'b1000, we 1.
  - Response rdata 0, err 0.
- Back-to-back:
  - Three requests issued on consecutive cycles: gnt drops after the second and re-asserts in the first RESP.
  - Responses come in order, one bus gap cycle between each.
- TIMEOUT_CYCLES = 8, no ack: cyc high exactly 8 cycles, then rvalid with err 1, rdata 0.
- Store with be = 0: no cyc at all, rvalid 1 cycle after accept.
- ack_i and err_i asserted together: err 1.
- rst pulsed while in BUS with pending valid: cyc 0 immediately, no rvalid afterwards, gnt 1 after release.
